// File: rtl/expression_tokenizer.sv
// expression_tokenizer: ASCII characters -> operand/operator tokens for expression_parser_top.
// Latency: a token is asserted one cycle after its character is decoded in IDLE; char_ack follows token release.
// Backpressure: four-phase on both sides; a character is acked only after all its tokens are released.
// Optional feature: define EXPRESSION_TOKENIZER_UNARY_MINUS_EN to fold a leading '-' into the next operand.
module expression_tokenizer #(
  parameter int DIGIT_MAX = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_stb,
  input  logic [7:0]  char_data,
  output logic        char_ack,
  output logic        tok_stb,
  output logic [31:0] tok_data,
  output logic        tok_is_op,
  input  logic        tok_ack,
  output logic        err,
  output logic        busy
);

  localparam int DW = $clog2(DIGIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NUM_TX,
    S_NUM_REL,
    S_OP_TX,
    S_OP_REL,
    S_CACK
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_acc;
  logic          r_pend;
  logic [DW-1:0] r_digits;
  logic          r_err;
  logic [31:0]   r_tok_data;
  logic          r_tok_is_op;
  logic [2:0]    r_op_code;
  logic          r_op_pend;

  logic          w_is_digit;
  logic          w_is_space;
  logic          w_is_op;
  logic [2:0]    w_op_code;
  logic [35:0]   w_prod;
  logic          w_ovf;
  logic          w_unary;
  logic [31:0]   w_operand;

`ifdef EXPRESSION_TOKENIZER_UNARY_MINUS_EN
  logic          r_neg;
  logic          r_at_start;
`endif

  assign w_is_digit = (char_data >= 8'h30) && (char_data <= 8'h39);
  assign w_is_space = (char_data == 8'h20);
  // 36 bits is enough for (2^32-1)*10+9, so the top nibble flags wrap-around.
  assign w_prod     = ({4'b0, r_acc} * 36'd10) + {32'b0, char_data[3:0]};
  assign w_ovf      = |w_prod[35:32];

`ifdef EXPRESSION_TOKENIZER_UNARY_MINUS_EN
  assign w_unary   = w_is_op && (w_op_code == 3'd1) && !r_pend && r_at_start;
  assign w_operand = r_neg ? (32'd0 - r_acc) : r_acc;
`else
  assign w_unary   = 1'b0;
  assign w_operand = r_acc;
`endif

  assign tok_data  = r_tok_data;
  assign tok_is_op = r_tok_is_op;
  assign err       = r_err;

  // Operator character to 3-bit parser code.
  always_comb begin
    w_is_op   = 1'b1;
    w_op_code = 3'd0;
    case (char_data)
      8'h2B:   w_op_code = 3'd0;  // '+'
      8'h2D:   w_op_code = 3'd1;  // '-'
      8'h2A:   w_op_code = 3'd2;  // '*'
      8'h2F:   w_op_code = 3'd3;  // '/'
      8'h5E:   w_op_code = 3'd4;  // '^'
      8'h3D:   w_op_code = 3'd5;  // '='
      8'h28:   w_op_code = 3'd6;  // '('
      8'h29:   w_op_code = 3'd7;  // ')'
      default: w_is_op   = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; outputs are pure functions of state so reset drops them at once.
  always_comb begin
    w_state_nxt = r_state;
    tok_stb     = 1'b0;
    char_ack    = 1'b0;
    busy        = (r_state != S_IDLE) || r_pend;
    case (r_state)
      S_IDLE: begin
        if (char_stb) begin
          if (w_unary)                      w_state_nxt = S_CACK;
          else if (w_is_op)                 w_state_nxt = r_pend ? S_NUM_TX : S_OP_TX;
          else if (w_is_space && r_pend)    w_state_nxt = S_NUM_TX;  // space splits operands
          else                              w_state_nxt = S_CACK;
        end
      end
      S_NUM_TX: begin
        tok_stb = 1'b1;
        if (tok_ack) w_state_nxt = S_NUM_REL;
      end
      S_NUM_REL: begin
        if (!tok_ack) w_state_nxt = r_op_pend ? S_OP_TX : S_CACK;
      end
      S_OP_TX: begin
        tok_stb = 1'b1;
        if (tok_ack) w_state_nxt = S_OP_REL;
      end
      S_OP_REL: begin
        if (!tok_ack) w_state_nxt = S_CACK;
      end
      S_CACK: begin
        char_ack = 1'b1;
        if (!char_stb) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand accumulation, token capture and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= 32'd0;
      r_pend      <= 1'b0;
      r_digits    <= '0;
      r_err       <= 1'b0;
      r_tok_data  <= 32'd0;
      r_tok_is_op <= 1'b0;
      r_op_code   <= 3'd0;
      r_op_pend   <= 1'b0;
`ifdef EXPRESSION_TOKENIZER_UNARY_MINUS_EN
      r_neg       <= 1'b0;
      r_at_start  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (char_stb) begin
            if (w_is_digit) begin
              if (r_digits >= DW'(DIGIT_MAX)) begin
                r_err <= 1'b1;  // digit dropped
              end else begin
                r_acc    <= w_prod[31:0];
                r_pend   <= 1'b1;
                r_digits <= r_digits + DW'(1);
                if (w_ovf) r_err <= 1'b1;
              end
            end else if (w_is_op || w_is_space) begin
              // Flush the pending operand; the operator (if any) follows from NUM_REL.
              if (r_pend) begin
                r_tok_data  <= w_operand;
                r_tok_is_op <= 1'b0;
                r_acc       <= 32'd0;
                r_pend      <= 1'b0;
                r_digits    <= '0;
`ifdef EXPRESSION_TOKENIZER_UNARY_MINUS_EN
                r_neg       <= 1'b0;
                r_at_start  <= 1'b0;
`endif
              end
              if (w_is_op && !w_unary) begin
                r_op_code <= w_op_code;
                r_op_pend <= r_pend;
                if (!r_pend) begin
                  r_tok_data  <= {29'b0, w_op_code};
                  r_tok_is_op <= 1'b1;
                end
              end
`ifdef EXPRESSION_TOKENIZER_UNARY_MINUS_EN
              if (w_is_op) begin
                if (w_unary) begin
                  r_neg <= ~r_neg;
                end else begin
                  r_at_start <= (w_op_code != 3'd7);
                  if (w_op_code == 3'd5) r_neg <= 1'b0;
                end
              end
`endif
            end else begin
              // Unknown byte: consumed without a token; any operand keeps accumulating state.
              r_err <= 1'b1;
            end
          end
        end
        S_NUM_REL: begin
          // Operator token loaded only once the operand token is fully released.
          if (!tok_ack && r_op_pend) begin
            r_tok_data  <= {29'b0, r_op_code};
            r_tok_is_op <= 1'b1;
            r_op_pend   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expression_tokenizer.sv
// Bench for expression_tokenizer: character source + parser responder with a token scoreboard.
// Latency: responder acks one cycle after seeing tok_stb unless a hold is requested.
// Backpressure: a one-shot hold keeps tok_ack low for a chosen number of cycles.
module tb_expression_tokenizer;

  logic        clk;
  logic        rst;
  logic        char_stb;
  logic [7:0]  char_data;
  logic        char_ack;
  logic        tok_stb;
  logic [31:0] tok_data;
  logic        tok_is_op;
  logic        tok_ack;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_tok = 0;
  int hold  = 0;
  bit resp_en = 1'b1;

  logic [32:0] sb[$];

  expression_tokenizer #(.DIGIT_MAX(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_stb  (char_stb),
    .char_data (char_data),
    .char_ack  (char_ack),
    .tok_stb   (tok_stb),
    .tok_data  (tok_data),
    .tok_is_op (tok_is_op),
    .tok_ack   (tok_ack),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_tok(input logic [31:0] d, input logic op);
    sb.push_back({op, d});
  endtask

  task automatic send_char(input byte c);
    int t;
    char_data = c;
    char_stb  = 1'b1;
    t = 0;
    while (char_ack !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("cack_rise", char_ack, 1);
    char_stb = 1'b0;
    t = 0;
    while (char_ack !== 1'b0 && t < 10) begin
      @(posedge clk); #1; t++;
    end
    chk("cack_fall", char_ack, 0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Parser model: pops the expected token, checks it, and completes the four-phase handshake.
  initial begin
    logic [32:0] got;
    logic [32:0] e;
    bit unstable;
    bit early;
    int t;
    tok_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tok_stb && resp_en) begin
        got = {tok_is_op, tok_data};
        n_tok++;
        chk("tok_expected_present", (sb.size() == 0), 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("tok", got, e);
        end
        if (hold > 0) begin
          unstable = 1'b0;
          early    = 1'b0;
          repeat (hold) begin
            @(posedge clk); #1;
            if (tok_stb !== 1'b1 || {tok_is_op, tok_data} !== got) unstable = 1'b1;
            if (char_ack !== 1'b0) early = 1'b1;
          end
          hold = 0;
          chk("hold_tok_stable", unstable, 0);
          chk("hold_no_cack", early, 0);
        end
        tok_ack = 1'b1;
        t = 0;
        do begin
          @(posedge clk); #1; t++;
        end while (tok_stb === 1'b1 && t < 20);
        chk("tok_stb_drop", tok_stb, 0);
        chk("tok_held_until_ack_low", {tok_is_op, tok_data}, got);
        tok_ack = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tok_before;
    rst       = 1'b1;
    char_stb  = 1'b0;
    char_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_ack", char_ack, 0);
    chk("rst_tok_stb", tok_stb, 0);
    chk("rst_tok_data", tok_data, 0);
    chk("rst_tok_is_op", tok_is_op, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Mixed operators and parentheses.
    exp_tok(5, 0); exp_tok(2, 1); exp_tok(6, 1); exp_tok(3, 0);
    exp_tok(0, 1); exp_tok(4, 0); exp_tok(7, 1); exp_tok(5, 1);
    send_str("5*(3+4)=");
    chk("expr1_err", err, 0);
    chk("expr1_busy", busy, 0);

    // Space separates two operands.
    exp_tok(12, 0); exp_tok(34, 0); exp_tok(5, 1);
    send_str("12 34=");
    chk("space_err", err, 0);

    // 32-bit overflow wraps and sets err.
    exp_tok(0, 0); exp_tok(5, 1);
    send_str("4294967296=");
    chk("ovf_err", err, 1);
    pulse_rst();
    chk("ovf_err_cleared", err, 0);

    // Invalid byte consumed without a token.
    exp_tok(7, 0); exp_tok(5, 1);
    send_str("7x=");
    chk("inv_err", err, 1);
    pulse_rst();

    // Too many digits: 11th digit dropped.
    exp_tok(32'd1234567890, 0); exp_tok(5, 1);
    send_str("12345678901=");
    chk("digits_err", err, 1);
    pulse_rst();

    // Back-pressure on the operand token flushed by '*'.
    exp_tok(3, 0); exp_tok(2, 1); exp_tok(2, 0); exp_tok(5, 1);
    send_char("3");
    hold = 20;
    tok_before = n_tok;
    send_char("*");
    chk("bp_star_tokens", n_tok - tok_before, 2);
    send_str("2=");
    chk("bp_err", err, 0);

    // Leading minus.
`ifdef EXPRESSION_TOKENIZER_UNARY_MINUS_EN
    exp_tok(32'hFFFF_FFF9, 0); exp_tok(5, 1);
`else
    exp_tok(1, 1); exp_tok(7, 0); exp_tok(5, 1);
`endif
    send_str("-7=");
    chk("neg_err", err, 0);

    // Reset while an operand token is asserted.
    resp_en = 1'b0;
    send_char("7");
    char_data = "=";
    char_stb  = 1'b1;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (tok_stb !== 1'b1 && t < 10);
    chk("numtx_latency", t, 1);
    chk("numtx_tok", {tok_is_op, tok_data}, {1'b0, 32'd7});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tok_stb", tok_stb, 0);
    chk("midrst_char_ack", char_ack, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tok_data", tok_data, 0);
    rst      = 1'b0;
    char_stb = 1'b0;
    resp_en  = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle_tok_stb", tok_stb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
